// File: rtl/gb132_pkg.sv
// ============================================================================
//  gb132_pkg
//  Shared sync-header codes, block-sync state encoding and header check.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package gb132_pkg;

    localparam logic [3:0] HDR_DATA = 4'b0011;
    localparam logic [3:0] HDR_CTRL = 4'b1100;

    typedef logic [1:0] state_t;

    localparam state_t ST_HUNT   = 2'd0;
    localparam state_t ST_WAIT   = 2'd1;
    localparam state_t ST_VERIFY = 2'd2;
    localparam state_t ST_LOCKED = 2'd3;

    function automatic logic hdr_valid(input logic [3:0] hdr);
        return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/block_sync_132_sat_cnt.sv
// ============================================================================
//  sat_cnt
//  Saturating event counter, holds at all-ones.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/block_sync_132.sv
// ============================================================================
//  block_sync_132
//  132-bit block lock: sync-header hunt/verify/lock, slip requests, payload out.
//  Optional BLOCK_SYNC_STATS_EN adds hdr_err_cnt / lock_loss_cnt outputs.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module block_sync_132
    import gb132_pkg::*;
#(
    parameter int LOCK_CNT  = 64,
    parameter int ERR_WIN   = 64,
    parameter int ERR_MAX   = 16,
    parameter int SLIP_WAIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [131:0] din,
    input  logic         din_valid,
    output logic         slip,
    output logic         block_lock,
    output logic [127:0] dout,
    output logic         dout_ctrl,
    output logic         dout_err,
    output logic         dout_valid
`ifdef BLOCK_SYNC_STATS_EN
    ,
    output logic [15:0]  hdr_err_cnt,
    output logic [7:0]   lock_loss_cnt
`endif
);

    localparam int c_GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int c_BLK_W  = $clog2(ERR_WIN + 1);
    localparam int c_BAD_W  = $clog2(ERR_MAX + 1);
    localparam int c_WAIT_W = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;

    localparam logic [c_GOOD_W-1:0] c_LOCK_LAST = c_GOOD_W'(LOCK_CNT - 1);
    localparam logic [c_BLK_W-1:0]  c_WIN_LAST  = c_BLK_W'(ERR_WIN - 1);
    localparam logic [c_BAD_W-1:0]  c_ERR_LAST  = c_BAD_W'(ERR_MAX - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_INIT = c_WAIT_W'(SLIP_WAIT);

    state_t              state_q,  state_d;
    logic [c_GOOD_W-1:0] good_q,   good_d;
    logic [c_BLK_W-1:0]  blk_q,    blk_d;
    logic [c_BAD_W-1:0]  bad_q,    bad_d;
    logic [c_WAIT_W-1:0] wait_q,   wait_d;

    logic         slip_q,  slip_d;
    logic         lock_q,  lock_d;
    logic         vld_q,   vld_d;
    logic         ctrl_q,  ctrl_d;
    logic         err_q,   err_d;
    logic [127:0] dout_q;

    logic w_hdr_ok;
    logic w_go_wait;
    logic w_fwd;

    assign w_hdr_ok = hdr_valid(din[131:128]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
            good_q  <= '0;
            blk_q   <= '0;
            bad_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            blk_q   <= blk_d;
            bad_q   <= bad_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        blk_d     = blk_q;
        bad_d     = bad_q;
        wait_d    = wait_q;
        w_go_wait = 1'b0;
        w_fwd     = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (din_valid) begin
                    if (w_hdr_ok) begin
                        state_d = ST_VERIFY;
                        good_d  = c_GOOD_W'(1);
                    end else begin
                        w_go_wait = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // Counts every clock; returning to HUNT as the count reaches zero.
                wait_d = (wait_q == '0) ? '0 : wait_q - 1'b1;
                if (wait_q <= c_WAIT_W'(1)) begin
                    state_d = ST_HUNT;
                end
            end
            ST_VERIFY: begin
                if (din_valid) begin
                    if (!w_hdr_ok) begin
                        w_go_wait = 1'b1;
                    end else if (good_q == c_LOCK_LAST) begin
                        state_d = ST_LOCKED;
                        blk_d   = '0;
                        bad_d   = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
            end
            default: begin
                if (din_valid) begin
                    // Lock loss is checked before the window-end reset.
                    if (!w_hdr_ok && (bad_q == c_ERR_LAST)) begin
                        w_go_wait = 1'b1;
                    end else if (blk_q == c_WIN_LAST) begin
                        w_fwd = 1'b1;
                        blk_d = '0;
                        bad_d = '0;
                    end else begin
                        w_fwd = 1'b1;
                        blk_d = blk_q + 1'b1;
                        bad_d = bad_q + c_BAD_W'(!w_hdr_ok);
                    end
                end
            end
        endcase
        if (w_go_wait) begin
            state_d = ST_WAIT;
            wait_d  = c_WAIT_INIT;
            good_d  = '0;
        end
    end

    always_comb begin
        slip_d = w_go_wait;
        lock_d = (state_d == ST_LOCKED);
        vld_d  = w_fwd;
        ctrl_d = ctrl_q;
        err_d  = err_q;
        if (w_fwd) begin
            ctrl_d = (din[131:128] == HDR_CTRL);
            err_d  = !w_hdr_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slip_q <= 1'b0;
            lock_q <= 1'b0;
            vld_q  <= 1'b0;
            ctrl_q <= 1'b0;
            err_q  <= 1'b0;
            dout_q <= '0;
        end else begin
            slip_q <= slip_d;
            lock_q <= lock_d;
            vld_q  <= vld_d;
            ctrl_q <= ctrl_d;
            err_q  <= err_d;
            if (w_fwd) begin
                dout_q <= din[127:0];
            end
        end
    end

    assign slip       = slip_q;
    assign block_lock = lock_q;
    assign dout       = dout_q;
    assign dout_ctrl  = ctrl_q;
    assign dout_err   = err_q;
    assign dout_valid = vld_q;

`ifdef BLOCK_SYNC_STATS_EN
    logic w_hdr_err_inc;
    logic w_lock_loss_inc;

    assign w_hdr_err_inc   = din_valid && !w_hdr_ok && (state_q != ST_WAIT);
    assign w_lock_loss_inc = (state_q == ST_LOCKED) && w_go_wait;

    sat_cnt #(.WIDTH(16)) u_hdr_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (w_hdr_err_inc),
        .cnt_o (hdr_err_cnt)
    );

    sat_cnt #(.WIDTH(8)) u_lock_loss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (w_lock_loss_inc),
        .cnt_o (lock_loss_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_block_sync_132.sv
// ============================================================================
//  tb_block_sync_132
//  Scoreboarded bench for block_sync_132: lock, hunt, error window, cadence, reset.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_block_sync_132;

    localparam int         LOCK_CNT  = 64;
    localparam int         SLIP_WAIT = 4;
    localparam logic [3:0] H_D   = 4'b0011;
    localparam logic [3:0] H_C   = 4'b1100;
    localparam logic [3:0] H_BAD = 4'b0101;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic [131:0] din       = '0;
    logic         din_valid = 1'b0;
    logic         slip;
    logic         block_lock;
    logic [127:0] dout;
    logic         dout_ctrl;
    logic         dout_err;
    logic         dout_valid;
`ifdef BLOCK_SYNC_STATS_EN
    logic [15:0]  hdr_err_cnt;
    logic [7:0]   lock_loss_cnt;
`endif

    int n_vec  = 0;
    int n_err  = 0;
    int n_slip = 0;
    int cad    = 0;

    logic [129:0] sb[$];
    logic [129:0] exp_word;

    always #5 clk = ~clk;

    block_sync_132 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .slip       (slip),
        .block_lock (block_lock),
        .dout       (dout),
        .dout_ctrl  (dout_ctrl),
        .dout_err   (dout_err),
        .dout_valid (dout_valid)
`ifdef BLOCK_SYNC_STATS_EN
        ,
        .hdr_err_cnt   (hdr_err_cnt),
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    // Scoreboard side: every forwarded block must match the oldest expectation.
    always @(negedge clk) begin
        if (slip) n_slip++;
        if (dout_valid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_dout: got dout_valid=1 dout=%h, required no output", dout);
            end else begin
                exp_word = sb.pop_front();
                if ({dout_ctrl, dout_err, dout} !== exp_word) begin
                    n_err++;
                    $display("FAIL dout_word: got ctrl=%b err=%b dout=%h, required ctrl=%b err=%b dout=%h",
                             dout_ctrl, dout_err, dout, exp_word[129], exp_word[128], exp_word[127:0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic blk(input logic [3:0] h, input bit fwd);
        logic [127:0] p;
        logic         hv;
        p  = {$urandom(), $urandom(), $urandom(), $urandom()};
        hv = (h == H_D) || (h == H_C);
        if (fwd) sb.push_back({(h == H_C), !hv, p});
        din       = {h, p};
        din_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Gap cycle carries an invalid header that must be ignored.
    task automatic cblk(input logic [3:0] h, input bit fwd);
        if (cad == 32) begin
            din       = {H_BAD, 128'h0};
            din_valid = 1'b0;
            @(posedge clk);
            #1;
            cad = 0;
        end
        blk(h, fwd);
        cad++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        sb.delete();
        cad = 0;
    endtask

    task automatic do_lock();
        for (int i = 0; i < LOCK_CNT; i++) blk(H_D, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        n_vec++; if (slip !== 1'b0)       begin n_err++; $display("FAIL rst_slip: got %b, required 0", slip); end
        n_vec++; if (block_lock !== 1'b0) begin n_err++; $display("FAIL rst_lock: got %b, required 0", block_lock); end
        n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, required 0", dout_valid); end
        n_vec++; if (dout !== 128'h0)     begin n_err++; $display("FAIL rst_dout: got %h, required 0", dout); end
        n_vec++; if ({dout_ctrl, dout_err} !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %b, required 00", {dout_ctrl, dout_err}); end
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        int s0;
        s0 = n_slip;
        for (int i = 0; i < LOCK_CNT - 1; i++) blk(H_D, 1'b0);
        n_vec++; if (block_lock !== 1'b0) begin n_err++; $display("FAIL lock_early: got %b, required 0", block_lock); end
        blk(H_D, 1'b0);
        n_vec++; if (block_lock !== 1'b1) begin n_err++; $display("FAIL lock_at_64: got %b, required 1", block_lock); end
        n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL lock_blk_fwd: got %b, required 0", dout_valid); end
        blk(H_D, 1'b1);
        n_vec++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL first_fwd: got %b, required 1", dout_valid); end
        blk(H_C, 1'b1);
        blk(H_D, 1'b1);
        idle(2);
        n_vec++; if (n_slip != s0) begin n_err++; $display("FAIL lock_slips: got %0d, required %0d", n_slip, s0); end
    endtask

    task automatic test_hunt();
        int  k;
        bit  seen;
        do_reset();
        blk(4'b0000, 1'b0);
        n_vec++; if (slip !== 1'b1) begin n_err++; $display("FAIL hunt_slip1: got %b, required 1", slip); end
        din  = {4'b1111, 128'h0};
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(posedge clk);
            #1;
            k++;
            if (slip === 1'b1) seen = 1'b1;
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL hunt_slip2: got no slip in 20 clk, required a slip"); end
        n_vec++; if (k < SLIP_WAIT + 1) begin n_err++; $display("FAIL hunt_spacing: got %0d clk, required >= %0d", k, SLIP_WAIT + 1); end
        n_vec++; if (block_lock !== 1'b0) begin n_err++; $display("FAIL hunt_lock: got %b, required 0", block_lock); end
        idle(10);
    endtask

    task automatic test_err_window();
        int s0;
        do_reset();
        do_lock();
        s0 = n_slip;
        for (int i = 0; i < 15; i++) begin
            blk(H_D, 1'b1);
            blk(H_BAD, 1'b1);
        end
        n_vec++; if (block_lock !== 1'b1) begin n_err++; $display("FAIL err15_lock: got %b, required 1", block_lock); end
        n_vec++; if (n_slip != s0) begin n_err++; $display("FAIL err15_slip: got %0d, required %0d", n_slip, s0); end
        blk(H_BAD, 1'b0);
        n_vec++; if (slip !== 1'b1)       begin n_err++; $display("FAIL err16_slip: got %b, required 1", slip); end
        n_vec++; if (block_lock !== 1'b0) begin n_err++; $display("FAIL err16_lock: got %b, required 0", block_lock); end
        n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL err16_fwd: got %b, required 0", dout_valid); end
        idle(10);
    endtask

    task automatic test_window_reset();
        int s0;
        do_lock();
        n_vec++; if (block_lock !== 1'b1) begin n_err++; $display("FAIL relock: got %b, required 1", block_lock); end
        s0 = n_slip;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 64; i++) begin
                if (i < 15) blk(H_BAD, 1'b1);
                else        blk((i % 2) ? H_C : H_D, 1'b1);
            end
        end
        idle(2);
        n_vec++; if (block_lock !== 1'b1) begin n_err++; $display("FAIL win_lock: got %b, required 1", block_lock); end
        n_vec++; if (n_slip != s0) begin n_err++; $display("FAIL win_slip: got %0d, required %0d", n_slip, s0); end
    endtask

    task automatic test_cadence();
        int s0;
        do_reset();
        for (int i = 0; i < LOCK_CNT - 1; i++) cblk(H_D, 1'b0);
        n_vec++; if (block_lock !== 1'b0) begin n_err++; $display("FAIL cad_early: got %b, required 0", block_lock); end
        cblk(H_D, 1'b0);
        n_vec++; if (block_lock !== 1'b1) begin n_err++; $display("FAIL cad_lock: got %b, required 1", block_lock); end
        s0 = n_slip;
        for (int i = 0; i < 64; i++) begin
            if ((i % 4 == 0) && (i < 60)) cblk(H_BAD, 1'b1);
            else                          cblk((i % 3 == 0) ? H_C : H_D, 1'b1);
        end
        idle(2);
        n_vec++; if (block_lock !== 1'b1) begin n_err++; $display("FAIL cad_keep: got %b, required 1", block_lock); end
        n_vec++; if (n_slip != s0) begin n_err++; $display("FAIL cad_slip: got %0d, required %0d", n_slip, s0); end
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL cad_pending: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_reset_async();
        blk(H_D, 1'b1);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (block_lock !== 1'b0) begin n_err++; $display("FAIL arst_lock: got %b, required 0", block_lock); end
        n_vec++; if (dout !== 128'h0)     begin n_err++; $display("FAIL arst_dout: got %h, required 0", dout); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        for (int i = 0; i < LOCK_CNT - 1; i++) blk(H_D, 1'b0);
        n_vec++; if (block_lock !== 1'b0) begin n_err++; $display("FAIL arst_relock_early: got %b, required 0", block_lock); end
        blk(H_D, 1'b0);
        n_vec++; if (block_lock !== 1'b1) begin n_err++; $display("FAIL arst_relock: got %b, required 1", block_lock); end
        do_reset();
        blk(4'b0000, 1'b0);
        din_valid = 1'b0;
`ifdef BLOCK_SYNC_STATS_EN
        n_vec++; if (hdr_err_cnt !== 16'd1) begin n_err++; $display("FAIL stats_hdr: got %0d, required 1", hdr_err_cnt); end
`endif
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (slip !== 1'b0) begin n_err++; $display("FAIL arst_wait_slip: got %b, required 0", slip); end
`ifdef BLOCK_SYNC_STATS_EN
        n_vec++; if (hdr_err_cnt !== 16'd0)  begin n_err++; $display("FAIL stats_hdr_rst: got %0d, required 0", hdr_err_cnt); end
        n_vec++; if (lock_loss_cnt !== 8'd0) begin n_err++; $display("FAIL stats_loss_rst: got %0d, required 0", lock_loss_cnt); end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_lock();
        n_vec++; if (block_lock !== 1'b1) begin n_err++; $display("FAIL wait_relock: got %b, required 1", block_lock); end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_lock();
        test_hunt();
        test_err_window();
        test_window_reset();
        test_cadence();
        test_reset_async();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
